// File: rtl/spi_mem_pkg.sv
// Shared types for the CPU-to-SPI memory bridge: access sizes, bridge states, SPI byte-mask codes.
// Latency: none (types, constants and a pure byte-swap helper only).
// Backpressure: not applicable.
package spi_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_XFER   = 2'b10,
        ST_DONE   = 2'b11
    } bridge_state_e;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    // The SPI wire order is most-significant byte first, the CPU is little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/spi_mem_lane_fmt.sv
// Byte-lane formatter: swaps store data into SPI wire order and extracts/extends load data.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module spi_mem_lane_fmt
    import spi_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_spi_rdata,
    output logic [31:0] o_spi_wdata,
    output logic [31:0] o_load_data,
    output logic [1:0]  o_byte_mask
);

    mem_size_e   w_size;
    logic [31:0] w_le;
    logic        w_sx;

    assign w_size      = mem_size_e'(i_size);
    // First byte on the wire is the byte at the request address, so every size sends the full swap.
    assign o_spi_wdata = bswap32(i_wdata);

    // Reassemble received wire bytes little-endian, then trim to the access size and extend.
    always_comb begin
        w_le        = bswap32(i_spi_rdata);
        w_sx        = ~i_unsigned;
        o_load_data = w_le;
        o_byte_mask = MASK_WORD;
        unique case (w_size)
            SZ_BYTE: begin
                o_load_data = {{24{w_sx & w_le[7]}}, w_le[7:0]};
                o_byte_mask = MASK_BYTE;
            end
            SZ_HALF: begin
                o_load_data = {{16{w_sx & w_le[15]}}, w_le[15:0]};
                o_byte_mask = MASK_HALF;
            end
            SZ_WORD, SZ_WORD_ALT: begin
                o_load_data = w_le;
                o_byte_mask = MASK_WORD;
            end
            default: begin
                o_load_data = w_le;
                o_byte_mask = MASK_WORD;
            end
        endcase
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// CPU load/store to SPI-memory bridge; optional watchdog enabled by defining SPI_MEM_TIMEOUT_EN.
// Latency: accept + SPI busy/valid handshake + one DONE cycle carrying the mem_ready pulse.
// Backpressure: requests are taken only in IDLE; mem_req elsewhere is ignored, nothing is queued.
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [23:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err,
    input  logic        cfg_slow,
    output logic        spi_req,
    output logic        spi_write,
    output logic        spi_slow_mode,
    output logic [23:0] spi_addr,
    output logic [31:0] spi_data_in,
    output logic [1:0]  spi_byte_mask,
    input  logic [31:0] spi_data_out,
    input  logic        spi_busy,
    input  logic        spi_valid
);

    bridge_state_e r_state;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [23:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_slow;
    logic          r_spi_req;
    logic          r_ready;
    logic          r_err;
    logic [31:0]   r_rdata;

    logic [31:0]   w_load_data;
    logic          w_timeout;
    logic          w_accept;

    assign w_accept = (r_state == ST_IDLE) && mem_req;

    spi_mem_lane_fmt u_lane_fmt (
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .i_spi_rdata (spi_data_out),
        .o_spi_wdata (spi_data_in),
        .o_load_data (w_load_data),
        .o_byte_mask (spi_byte_mask)
    );

`ifdef SPI_MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;

    // Fires on the last counted cycle so DONE lands exactly TIMEOUT_CYCLES after accept.
    assign w_timeout = ((r_state == ST_LAUNCH) || (r_state == ST_XFER)) &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on accept, advances only while the SPI side owns the transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_accept) begin
            r_to_cnt <= '0;
        end else if (((r_state == ST_LAUNCH) || (r_state == ST_XFER)) && !w_timeout) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Bridge sequencer: latches the request, drives spi_req low until data or watchdog, pulses mem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_slow     <= 1'b0;
            r_spi_req  <= 1'b1;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (mem_req) begin
                        r_we       <= mem_we;
                        r_size     <= mem_size;
                        r_unsigned <= mem_unsigned;
                        r_addr     <= mem_addr;
                        r_wdata    <= mem_wdata;
                        r_slow     <= cfg_slow;
                        r_spi_req  <= 1'b0;
                        r_err      <= 1'b0;
                        r_state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (w_timeout) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_ready   <= 1'b1;
                        r_spi_req <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (spi_busy) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_timeout) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_ready   <= 1'b1;
                        r_spi_req <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (spi_valid) begin
                        r_rdata   <= r_we ? 32'h0 : w_load_data;
                        r_err     <= 1'b0;
                        r_ready   <= 1'b1;
                        r_spi_req <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rdata     = r_rdata;
    assign mem_ready     = r_ready;
    assign mem_err       = r_err;
    assign spi_req       = r_spi_req;
    assign spi_write     = r_we;
    assign spi_slow_mode = r_slow;
    assign spi_addr      = r_addr;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Randomized scoreboard bench for spi_mem_bridge with a byte-stream reference model and SPI slave model.
// Latency: checks mem_ready one cycle after spi_valid and back-to-back acceptance spacing.
// Backpressure: SPI slave model inserts random busy/valid delays per transaction.
module tb_spi_mem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;
    logic        cfg_slow;
    logic        spi_req;
    logic        spi_write;
    logic        spi_slow_mode;
    logic [23:0] spi_addr;
    logic [31:0] spi_data_in;
    logic [1:0]  spi_byte_mask;
    logic [31:0] spi_data_out;
    logic        spi_busy;
    logic        spi_valid;

    always #5 clk = ~clk;

    spi_mem_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err), .cfg_slow(cfg_slow),
        .spi_req(spi_req), .spi_write(spi_write), .spi_slow_mode(spi_slow_mode),
        .spi_addr(spi_addr), .spi_data_in(spi_data_in), .spi_byte_mask(spi_byte_mask),
        .spi_data_out(spi_data_out), .spi_busy(spi_busy), .spi_valid(spi_valid)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic        slow;
        logic [31:0] spi_d;
        int          d_busy;
        int          d_valid;
        bit          stall;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    txn_t txq[$];
    exp_t expq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cnt = 0;
    int ready_cnt = 0;
    int last_accept_cyc = 0;
    int last_ready_cyc = 0;
    bit prev_req = 1'b1;
    bit prev_valid = 1'b0;
    bit prev_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access is a little-endian run of N bytes taken from the wire stream.
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] size, input logic uns, input logic [31:0] d);
        int n;
        logic [31:0] v;
        n = nbytes(size);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(d[31-8*i -: 8]) << (8*i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic logic [31:0] exp_wire(input logic [31:0] w);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[31-8*i -: 8] = w[8*i +: 8];
        return v;
    endfunction

    function automatic logic [1:0] exp_mask(input logic [1:0] size);
        int n;
        n = nbytes(size);
        return (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we      = 1'($urandom_range(0, 1));
        t.size    = 2'($urandom_range(0, 3));
        t.uns     = 1'($urandom_range(0, 1));
        t.addr    = 24'($urandom);
        t.wdata   = $urandom;
        t.slow    = 1'($urandom_range(0, 1));
        t.spi_d   = $urandom;
        t.d_busy  = $urandom_range(1, 4);
        t.d_valid = $urandom_range(1, 5);
        t.stall   = 1'b0;
        return t;
    endfunction

    // SPI slave model: checks the launched command, then answers after random busy/valid delays.
    initial begin : spi_model
        txn_t cur;
        bit   active;
        int   scnt;
        active = 1'b0;
        scnt = 0;
        cur = rand_txn();
        spi_busy = 1'b0;
        spi_valid = 1'b0;
        spi_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            spi_valid = 1'b0;
            spi_data_out = $urandom;
            if (reset || spi_req) begin
                spi_busy = 1'b0;
                active = 1'b0;
            end else if (!active) begin
                active = 1'b1;
                scnt = 0;
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spi_start: got launch, expected no pending request");
                    cur.stall = 1'b1;
                end else begin
                    cur = txq.pop_front();
                    chk("spi_write", 32'(spi_write), 32'(cur.we));
                    chk("spi_addr", 32'(spi_addr), 32'(cur.addr));
                    chk("spi_data_in", spi_data_in, exp_wire(cur.wdata));
                    chk("spi_byte_mask", 32'(spi_byte_mask), 32'(exp_mask(cur.size)));
                    chk("spi_slow_mode", 32'(spi_slow_mode), 32'(cur.slow));
                end
            end else begin
                scnt++;
                if (scnt == cur.d_busy) spi_busy = 1'b1;
                if (!cur.stall && scnt == cur.d_busy + cur.d_valid) begin
                    spi_valid = 1'b1;
                    spi_data_out = cur.spi_d;
                end
            end
        end
    end

    // Monitor: counts accepts, pops the scoreboard on every mem_ready and checks pulse timing.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (prev_req && !spi_req) begin
                    accept_cnt++;
                    last_accept_cyc = cyc;
                end
                if (prev_valid) chk("ready_after_valid", 32'(mem_ready), 32'd1);
                if (mem_ready) begin
                    ready_cnt++;
                    last_ready_cyc = cyc;
                    chk("ready_single_pulse", 32'(prev_ready), 32'd0);
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: got mem_ready=1 rdata=0x%08h, expected no response", mem_rdata);
                    end else begin
                        e = expq.pop_front();
                        chk("mem_rdata", mem_rdata, e.rdata);
                        chk("mem_err", 32'(mem_err), 32'(e.err));
                        if (e.err) chk("timeout_latency", 32'(cyc - last_accept_cyc), 32'd16);
                    end
                end
            end
            prev_req = spi_req;
            prev_valid = spi_valid;
            prev_ready = mem_ready;
        end
    end

    task automatic issue(input txn_t t, input bit hold_after);
        exp_t e;
        int start;
        int to;
        mem_we = t.we;
        mem_size = t.size;
        mem_unsigned = t.uns;
        mem_addr = t.addr;
        mem_wdata = t.wdata;
        cfg_slow = t.slow;
        mem_req = 1'b1;
        txq.push_back(t);
        e.err = t.stall;
        e.rdata = (t.we || t.stall) ? 32'h0 : exp_load(t.size, t.uns, t.spi_d);
        expq.push_back(e);
        start = accept_cnt;
        to = 0;
        while (accept_cnt == start && to < 200) begin
            @(negedge clk);
            to++;
        end
        if (accept_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", to);
        end
        if (!hold_after) mem_req = 1'b0;
    endtask

    task automatic drain();
        int to;
        to = 0;
        while (expq.size() != 0 && to < 300) begin
            @(negedge clk);
            to++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", expq.size());
            expq.delete();
            txq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got hung simulation, expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin : driver
        txn_t t;
        txn_t t2;
        int r0;
        int to;
        reset = 1'b1;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_size = 2'b00;
        mem_unsigned = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        cfg_slow = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_spi_req", 32'(spi_req), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_spi_addr", 32'(spi_addr), 32'd0);
        chk("rst_spi_data_in", spi_data_in, 32'd0);
        chk("rst_spi_write", 32'(spi_write), 32'd0);
        chk("rst_spi_mask", 32'(spi_byte_mask), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Store word: wire order 44 33 22 11.
        t = rand_txn();
        t.we = 1'b1; t.size = 2'b10; t.addr = 24'h000100; t.wdata = 32'h11223344;
        issue(t, 1'b0);
        drain();

        // Signed and unsigned byte loads of 0x80.
        t = rand_txn();
        t.we = 1'b0; t.size = 2'b00; t.uns = 1'b0; t.addr = 24'h000005; t.spi_d = 32'h80A5_5A3C;
        issue(t, 1'b0);
        drain();
        t.uns = 1'b1;
        issue(t, 1'b0);
        drain();

        // Unaligned half load.
        t = rand_txn();
        t.we = 1'b0; t.size = 2'b01; t.uns = 1'b0; t.addr = 24'h000003; t.spi_d = 32'h3412_F00D;
        issue(t, 1'b0);
        drain();

        // Reset during XFER aborts the transfer; the next request completes normally.
        t = rand_txn();
        t.we = 1'b0; t.d_busy = 1; t.d_valid = 40;
        issue(t, 1'b0);
        to = 0;
        while (!spi_busy && to < 50) begin
            @(negedge clk);
            to++;
        end
        chk("rst_mid_busy_seen", 32'(spi_busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_spi_req", 32'(spi_req), 32'd1);
        chk("rst_mid_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mid_mem_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        txq.delete();
        expq.delete();
        @(negedge clk);
        t = rand_txn();
        t.we = 1'b0; t.size = 2'b10;
        issue(t, 1'b0);
        drain();

        // Back-to-back with mem_req held high.
        t = rand_txn();
        t2 = rand_txn();
        issue(t, 1'b1);
        r0 = ready_cnt;
        issue(t2, 1'b0);
        chk("b2b_gap", 32'(last_accept_cyc - last_ready_cyc), 32'd2);
        drain();
        chk("b2b_pulses", 32'(ready_cnt - r0), 32'd2);

`ifdef SPI_MEM_TIMEOUT_EN
        // SPI never answers: watchdog completes with mem_err.
        t = rand_txn();
        t.we = 1'b0; t.stall = 1'b1;
        issue(t, 1'b0);
        drain();
        chk("timeout_spi_req", 32'(spi_req), 32'd1);
`endif

        // Random traffic, sometimes holding mem_req between transactions.
        for (int k = 0; k < 40; k++) begin
            t = rand_txn();
            issue(t, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        mem_req = 1'b0;
        drain();
        chk("final_queue_empty", 32'(txq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mem_bridge.md
SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: watchdog limit in clk cycles, used only when SPI_MEM_TIMEOUT_EN is defined.
REQ-002 clk  in  1  single clock; all logic on posedge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 mem_req  in  1  CPU request, sampled in IDLE only.
REQ-005 mem_we  in  1  1=store, 0=load.
REQ-006 mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-007 mem_unsigned  in  1  load zero-extend (1) or sign-extend (0).
REQ-008 mem_addr  in  24  byte address; no alignment required.
REQ-009 mem_wdata  in  32  little-endian store data, right-aligned.
REQ-010 mem_rdata  out  32  load result, valid while mem_ready=1.
REQ-011 mem_ready  out  1  one-cycle completion pulse.
REQ-012 mem_err  out  1  timeout flag, qualified by mem_ready.
REQ-013 cfg_slow  in  1  SPI clock divide-by-4 select, latched at accept.
REQ-014 spi_req  out  1  to SPI master; 1=idle/abort, 0=run transaction.
REQ-015 spi_write, spi_slow_mode  out  1 each; spi_addr out 24; spi_data_in out 32; spi_byte_mask out 2.
REQ-016 spi_data_out in 32; spi_busy in 1; spi_valid in 1 (from SPI master).

Function
REQ-017 States IDLE, LAUNCH, XFER, DONE; IDLE->LAUNCH when mem_req=1, latching we, size, unsigned, addr, wdata, cfg_slow.
REQ-018 LAUNCH: spi_req=0; ->XFER when spi_busy=1.
REQ-019 XFER: spi_req=0; ->DONE when spi_valid=1, capturing formatted read data that cycle.
REQ-020 DONE: spi_req=1, mem_ready=1 for exactly one cycle, ->IDLE; new request accepted the following cycle.
REQ-021 spi_req=1 in IDLE and DONE; spi_* data/control outputs driven from latched registers, stable for the whole transaction.
REQ-022 spi_byte_mask: byte->00, half->01, word/11->10.
REQ-023 spi_data_in = {w[7:0], w[15:8], w[23:16], w[31:24]} of latched wdata for all sizes (first byte on wire = byte at addr).
REQ-024 Load byte: rdata = ext(d[31:24]); half: ext({d[23:16], d[31:24]}); word: {d[7:0], d[15:8], d[23:16], d[31:24]}, where d=spi_data_out.
REQ-025 Sign extension uses the top received bit of the value; mem_unsigned=1 zero-fills.
REQ-026 Stores: mem_rdata=0 at mem_ready.
REQ-027 mem_req changes outside IDLE are ignored; no queueing.
REQ-028 Address wrap past 0xFFFFFF is not checked; spi_addr passes mem_addr unchanged.

Reset
REQ-029 reset=1 in any state, including mid-transaction: state IDLE, spi_req=1, mem_ready=0, mem_err=0, mem_rdata=0, latched registers 0; the in-flight SPI transfer is aborted via spi_req.

Configuration
REQ-030 SPI_MEM_TIMEOUT_EN defined: counter clears on accept and counts in LAUNCH and XFER.
REQ-031 With SPI_MEM_TIMEOUT_EN, reaching TIMEOUT_CYCLES forces DONE with mem_err=1 and mem_rdata=0.
REQ-032 SPI_MEM_TIMEOUT_EN undefined: no counter, mem_err tied 0, XFER waits indefinitely.

Structure
REQ-033 Package spi_mem_pkg holds the mem_size enum, the bridge state enum, and the SPI byte_mask constants.
REQ-034 One combinational sub-module, spi_mem_lane_fmt, performs the store byte-swap and the load extract/extend; the FSM stays in spi_mem_bridge.

Verification
REQ-035 Store word 0x11223344 @0x000100 -> spi_data_in=0x44332211, spi_byte_mask=10, spi_write=1; one mem_ready pulse after spi_valid.
REQ-036 Load byte @0x000005, unsigned=0, d[31:24]=0x80 -> mem_rdata=0xFFFFFF80; same with unsigned=1 -> 0x00000080.
REQ-037 Load half @0x000003 (unaligned), d=0x3412xxxx -> mem_rdata=0x00001234, spi_byte_mask=01.
REQ-038 reset asserted during XFER -> next cycle spi_req=1, mem_ready=0; the next request completes normally.
REQ-039 With SPI_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, spi_valid held 0 -> mem_ready=1 with mem_err=1 sixteen cycles after accept; spi_req returns to 1.
REQ-040 Back-to-back: mem_req held high across two transactions -> second accepted the cycle after mem_ready; exactly two mem_ready pulses.
